// File: rtl/fabric_memstream_ld.sv
// Streaming strided load initiator: issues addresses to a memory load port, buffers the
// paired data/done responses in a credit-bounded FIFO and re-emits them in order.
module fabric_memstream_ld #(
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = 0,
  parameter int TAG_VALUE       = 0,
  parameter int ADDR_WIDTH      = 8,
  parameter int COUNT_WIDTH     = 16,
  parameter int MAX_OUTSTANDING = 4,
  localparam int PW             = DATA_WIDTH + TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [ADDR_WIDTH-1:0]  start_base,
  input  logic [ADDR_WIDTH-1:0]  start_stride,
  input  logic [COUNT_WIDTH-1:0] start_count,
  output logic                   ld_addr_valid,
  input  logic                   ld_addr_ready,
  output logic [PW-1:0]          ld_addr_data,
  input  logic                   ld_data_valid,
  output logic                   ld_data_ready,
  input  logic [PW-1:0]          ld_data_data,
  input  logic                   ld_done_valid,
  output logic                   ld_done_ready,
  input  logic [PW-1:0]          ld_done_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   done_valid,
  input  logic                   done_ready,
  output logic                   error_valid,
  output logic [15:0]            error_code
);

  // Values mirror the shared fabric error code table.
  localparam logic [15:0] RT_MEMSTREAM_UNEXPECTED_RESP = 16'h0001;
  localparam logic [15:0] RT_MEMSTREAM_TAG_MISMATCH    = 16'h0002;

  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int TW    = (TAG_WIDTH > 0) ? TAG_WIDTH : 1;
  localparam logic [TW-1:0] TAG_CONST = TW'(TAG_VALUE);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d, stride_q;
  logic [COUNT_WIDTH-1:0] count_q, issued_q, issued_d, received_q, received_d;
  logic [CW-1:0]          outst_q, outst_d, fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]          addr_word_q, addr_word_d;
  logic                   err_valid_q, err_valid_d;
  logic [15:0]            err_code_q, err_code_d;
  logic [DATA_WIDTH-1:0]  fifo_mem [MAX_OUTSTANDING];

  logic [CW:0] inflight;
  logic fifo_full, fifo_empty, has_credit, tag_bad;
  logic start_fire, issue_fire, resp_fire, resp_unexp, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  generate
    if (TAG_WIDTH > 0) begin : g_tag
      assign addr_word_d = {TAG_CONST, DATA_WIDTH'(addr_d)};
      assign tag_bad     = (ld_done_data[PW-1:DATA_WIDTH] != TAG_CONST);
    end else begin : g_no_tag
      assign addr_word_d = DATA_WIDTH'(addr_d);
      assign tag_bad     = 1'b0;
    end
  endgenerate

  logic unused_ok;
  assign unused_ok = ^{ld_data_data, ld_done_data, TAG_CONST};

  assign inflight   = {1'b0, outst_q} + {1'b0, fifo_cnt_q};
  assign has_credit = (inflight < (CW+1)'(MAX_OUTSTANDING));
  assign fifo_full  = (fifo_cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (fifo_cnt_q == '0);

  assign start_ready   = (state_q == S_IDLE);
  assign ld_addr_valid = (state_q == S_ISSUE) && has_credit;
  assign ld_addr_data  = addr_word_q;
  assign ld_data_ready = !fifo_full;
  assign ld_done_ready = !fifo_full;
  assign out_valid     = !fifo_empty;
  assign out_data      = fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign done_valid    = (state_q == S_DONE);
  assign error_valid   = err_valid_q;
  assign error_code    = err_code_q;

  assign start_fire = start_valid && start_ready;
  assign issue_fire = ld_addr_valid && ld_addr_ready;
  assign resp_fire  = ld_data_valid && ld_done_valid && !fifo_full;
  assign resp_unexp = resp_fire && (outst_q == '0);
  assign push       = resp_fire && !resp_unexp;
  assign pop        = out_valid && out_ready;

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    addr_d     = addr_q;
    issued_d   = issued_q;
    received_d = received_q;
    outst_d    = outst_q;
    fifo_cnt_d = fifo_cnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (start_fire) begin
      addr_d     = start_base;
      issued_d   = '0;
      received_d = '0;
    end else if (issue_fire) begin
      addr_d   = addr_q + stride_q;
      issued_d = issued_q + 1'b1;
    end
    if (push) begin
      received_d = received_q + 1'b1;
      wr_ptr_d   = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (issue_fire && !push)      outst_d = outst_q + 1'b1;
    else if (push && !issue_fire) outst_d = outst_q - 1'b1;
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  // DRAIN looks at next-state counters so DONE is reached on the edge of the final pop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_fire) state_d = (start_count == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: if (issue_fire && issued_d == count_q) state_d = S_DRAIN;
      S_DRAIN: if (received_d == count_q && fifo_cnt_d == '0) state_d = S_DONE;
      S_DONE:  if (done_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    err_valid_d = err_valid_q;
    err_code_d  = err_code_q;
    if (!err_valid_q) begin
      if (resp_unexp) begin
        err_valid_d = 1'b1;
        err_code_d  = RT_MEMSTREAM_UNEXPECTED_RESP;
      end else if (push && tag_bad) begin
        err_valid_d = 1'b1;
        err_code_d  = RT_MEMSTREAM_TAG_MISMATCH;
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      addr_word_q <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      if (start_fire) begin
        stride_q <= start_stride;
        count_q  <= start_count;
      end
      if (start_fire || issue_fire) addr_word_q <= addr_word_d;
    end
  end

  // NOTE: the FIFO storage has no reset; out_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ld_data_data[DATA_WIDTH-1:0];
  end

endmodule

// File: tb/tb_fabric_memstream_ld.sv
// Directed bench for fabric_memstream_ld: a default-parameter instance with a one-cycle
// memory responder, plus a tagged instance driven by hand for the tag-mismatch path.
module tb_fabric_memstream_ld;

  localparam logic [15:0] CODE_UNEXP = 16'h0001;
  localparam logic [15:0] CODE_TAG   = 16'h0002;

  logic clk, rst_n;

  // Instance 0: DATA_WIDTH=32, TAG_WIDTH=0, ADDR_WIDTH=8, MAX_OUTSTANDING=4
  logic        st0_valid, st0_ready;
  logic [7:0]  st0_base, st0_stride;
  logic [15:0] st0_count;
  logic        la0_valid, la0_ready;
  logic [31:0] la0_data;
  logic        ld0_valid, ld0_ready, lc0_valid, lc0_ready;
  logic [31:0] ld0_data, lc0_data;
  logic        out0_valid, out0_ready;
  logic [31:0] out0_data;
  logic        dn0_valid, dn0_ready, err0_valid;
  logic [15:0] err0_code;

  // Instance 1: DATA_WIDTH=8, TAG_WIDTH=2, TAG_VALUE=1
  logic        st1_valid, st1_ready;
  logic [7:0]  st1_base, st1_stride;
  logic [15:0] st1_count;
  logic        la1_valid, la1_ready;
  logic [9:0]  la1_data;
  logic        ld1_valid, ld1_ready, lc1_valid, lc1_ready;
  logic [9:0]  ld1_data, lc1_data;
  logic        out1_valid, out1_ready;
  logic [7:0]  out1_data;
  logic        dn1_valid, dn1_ready, err1_valid;
  logic [15:0] err1_code;

  logic        inj0;
  logic [7:0]  addr_log[$];
  logic [31:0] out_log[$];
  logic [7:0]  pending[$];
  int          done_cnt = 0;
  int          n_cmp = 0, n_bad = 0;

  fabric_memstream_ld dut0 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(st0_valid), .start_ready(st0_ready), .start_base(st0_base),
    .start_stride(st0_stride), .start_count(st0_count),
    .ld_addr_valid(la0_valid), .ld_addr_ready(la0_ready), .ld_addr_data(la0_data),
    .ld_data_valid(ld0_valid), .ld_data_ready(ld0_ready), .ld_data_data(ld0_data),
    .ld_done_valid(lc0_valid), .ld_done_ready(lc0_ready), .ld_done_data(lc0_data),
    .out_valid(out0_valid), .out_ready(out0_ready), .out_data(out0_data),
    .done_valid(dn0_valid), .done_ready(dn0_ready),
    .error_valid(err0_valid), .error_code(err0_code)
  );

  fabric_memstream_ld #(.DATA_WIDTH(8), .TAG_WIDTH(2), .TAG_VALUE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(st1_valid), .start_ready(st1_ready), .start_base(st1_base),
    .start_stride(st1_stride), .start_count(st1_count),
    .ld_addr_valid(la1_valid), .ld_addr_ready(la1_ready), .ld_addr_data(la1_data),
    .ld_data_valid(ld1_valid), .ld_data_ready(ld1_ready), .ld_data_data(ld1_data),
    .ld_done_valid(lc1_valid), .ld_done_ready(lc1_ready), .ld_done_data(lc1_data),
    .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
    .done_valid(dn1_valid), .done_ready(dn1_ready),
    .error_valid(err1_valid), .error_code(err1_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] out_at(input int i);
    return (i < out_log.size()) ? out_log[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [7:0] addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : 8'hxx;
  endfunction

  task automatic start0(input logic [7:0] b, input logic [7:0] s, input logic [15:0] c);
    st0_base   = b;
    st0_stride = s;
    st0_count  = c;
    st0_valid  = 1'b1;
    step(1);
    st0_valid  = 1'b0;
  endtask

  task automatic wait_done0(input int target, input string tag);
    int i = 0;
    while (done_cnt < target && i < 300) begin
      step(1);
      i++;
    end
    check(tag, done_cnt, target);
  endtask

  // Monitor plus memory model for instance 0: mem[a] = a + 100, answered one cycle after issue.
  initial begin : responder0
    logic       a_fire, r_fire, inj_s;
    logic [7:0] a_addr, dummy;
    forever begin
      @(negedge clk);
      a_fire = la0_valid && la0_ready;
      a_addr = la0_data[7:0];
      r_fire = ld0_valid && ld0_ready && lc0_valid && lc0_ready;
      inj_s  = inj0;
      if (a_fire) addr_log.push_back(a_addr);
      if (out0_valid && out0_ready) out_log.push_back(out0_data);
      if (dn0_valid && dn0_ready) done_cnt++;
      @(posedge clk);
      #2;
      if (r_fire && !inj_s && pending.size() > 0) dummy = pending.pop_front();
      if (a_fire) pending.push_back(a_addr);
      if (!rst_n) pending.delete();
      ld0_valid = inj0 || (pending.size() > 0);
      lc0_valid = ld0_valid;
      ld0_data  = inj0 ? 32'hdead_beef : ((pending.size() > 0) ? 32'(pending[0]) + 32'd100 : 32'd0);
      lc0_data  = '0;
    end
  end

  initial begin
    int exp_wrap[4] = '{250, 253, 0, 3};
    int k, target;

    rst_n = 1'b0;
    inj0 = 1'b0;
    st0_valid = 1'b0; st0_base = '0; st0_stride = '0; st0_count = '0;
    la0_ready = 1'b1; out0_ready = 1'b1; dn0_ready = 1'b1;
    ld0_valid = 1'b0; lc0_valid = 1'b0; ld0_data = '0; lc0_data = '0;
    st1_valid = 1'b0; st1_base = '0; st1_stride = '0; st1_count = '0;
    la1_ready = 1'b1; out1_ready = 1'b1; dn1_ready = 1'b1;
    ld1_valid = 1'b0; lc1_valid = 1'b0; ld1_data = '0; lc1_data = '0;

    step(2);
    check("rst_start_ready", st0_ready, 1);
    check("rst_addr_valid", la0_valid, 0);
    check("rst_addr_data", la0_data, 0);
    check("rst_out_valid", out0_valid, 0);
    check("rst_out_data", out0_data, 0);
    check("rst_done_valid", dn0_valid, 0);
    check("rst_data_ready", ld0_ready, 1);
    check("rst_done_ready", lc0_ready, 1);
    check("rst_err_valid", err0_valid, 0);
    check("rst_err_code", err0_code, 0);
    check("rst_tag_addr_data", la1_data, 0);
    rst_n = 1'b1;
    step(1);

    // Basic: base 4, stride 1, count 4
    addr_log.delete(); out_log.delete();
    start0(8'd4, 8'd1, 16'd4);
    check("basic_first_valid", la0_valid, 1);
    check("basic_first_addr", la0_data, 4);
    check("basic_start_ready_low", st0_ready, 0);
    check("basic_no_out_yet", out0_valid, 0);
    step(2);
    check("basic_out_latency", out0_valid, 1);
    check("basic_head", out0_data, 104);
    wait_done0(1, "basic_done");
    step(3);
    for (int i = 0; i < 4; i++) check($sformatf("basic_out%0d", i), out_at(i), 104 + i);
    check("basic_done_once", done_cnt, 1);
    check("basic_no_error", err0_valid, 0);
    check("basic_start_ready_back", st0_ready, 1);

    // Address wrap: 250, 253, 0, 3
    addr_log.delete(); out_log.delete();
    start0(8'd250, 8'd3, 16'd4);
    wait_done0(2, "wrap_done");
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap_addr%0d", i), addr_at(i), exp_wrap[i]);
      check($sformatf("wrap_out%0d", i), out_at(i), exp_wrap[i] + 100);
    end

    // Backpressure: output stalled, credits cap issue at 4
    addr_log.delete(); out_log.delete();
    out0_ready = 1'b0;
    start0(8'd0, 8'd1, 16'd8);
    step(20);
    check("bp_issued_while_stalled", addr_log.size(), 4);
    check("bp_addr_valid_low", la0_valid, 0);
    check("bp_fifo_full_ready", ld0_ready, 0);
    check("bp_head", out0_data, 100);
    out0_ready = 1'b1;
    wait_done0(3, "bp_done");
    check("bp_issued_total", addr_log.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("bp_out%0d", i), out_at(i), 100 + i);

    // Zero count: straight to DONE
    addr_log.delete(); out_log.delete();
    dn0_ready = 1'b0;
    start0(8'd9, 8'd1, 16'd0);
    check("zero_done_valid", dn0_valid, 1);
    check("zero_no_issue", la0_valid, 0);
    check("zero_start_ready_low", st0_ready, 0);
    step(1);
    check("zero_done_held", dn0_valid, 1);
    dn0_ready = 1'b1;
    step(1);
    check("zero_start_ready_back", st0_ready, 1);
    check("zero_done_dropped", dn0_valid, 0);
    check("zero_no_addr_fires", addr_log.size(), 0);
    check("zero_done_count", done_cnt, 4);

    // Unsolicited response in IDLE
    inj0 = 1'b1;
    step(1);
    inj0 = 1'b0;
    check("unexp_err_valid", err0_valid, 1);
    check("unexp_err_code", err0_code, CODE_UNEXP);
    step(1);
    check("unexp_dropped", out0_valid, 0);

    // Tag mismatch on the tagged instance, then a later error must not overwrite the code
    st1_base = 8'd5; st1_stride = 8'd2; st1_count = 16'd2; st1_valid = 1'b1;
    step(1);
    st1_valid = 1'b0;
    check("tag_addr0_valid", la1_valid, 1);
    check("tag_addr0_data", la1_data, 10'h105);
    step(1);
    check("tag_addr1_data", la1_data, 10'h107);
    step(1);
    check("tag_drain_no_issue", la1_valid, 0);
    ld1_valid = 1'b1; lc1_valid = 1'b1; ld1_data = 10'h1a5; lc1_data = 10'h200;
    step(1);
    check("tag_err_valid", err1_valid, 1);
    check("tag_err_code", err1_code, CODE_TAG);
    check("tag_data_kept_valid", out1_valid, 1);
    check("tag_data_kept", out1_data, 8'ha5);
    ld1_data = 10'h15a; lc1_data = 10'h100;
    step(1);
    ld1_valid = 1'b0; lc1_valid = 1'b0;
    check("tag_second_data", out1_data, 8'h5a);
    step(1);
    check("tag_done_valid", dn1_valid, 1);
    step(1);
    ld1_valid = 1'b1; lc1_valid = 1'b1; ld1_data = 10'h111; lc1_data = 10'h100;
    step(1);
    ld1_valid = 1'b0; lc1_valid = 1'b0;
    check("tag_code_sticky", err1_code, CODE_TAG);
    check("tag_valid_sticky", err1_valid, 1);

    // Reset after 3 of 8 issues
    addr_log.delete(); out_log.delete();
    start0(8'd16, 8'd1, 16'd8);
    k = 0;
    while (addr_log.size() < 3 && k < 50) begin
      step(1);
      k++;
    end
    check("rstmid_three_issued", addr_log.size(), 3);
    rst_n = 1'b0;
    #1;
    check("rstmid_start_ready", st0_ready, 1);
    check("rstmid_addr_valid", la0_valid, 0);
    check("rstmid_addr_data", la0_data, 0);
    check("rstmid_out_valid", out0_valid, 0);
    check("rstmid_out_data", out0_data, 0);
    check("rstmid_done_valid", dn0_valid, 0);
    check("rstmid_data_ready", ld0_ready, 1);
    check("rstmid_done_ready", lc0_ready, 1);
    check("rstmid_err_valid", err0_valid, 0);
    check("rstmid_err_code", err0_code, 0);
    step(2);
    rst_n = 1'b1;
    step(1);
    addr_log.delete(); out_log.delete();
    target = done_cnt + 1;
    start0(8'd40, 8'd1, 16'd3);
    wait_done0(target, "rstmid_fresh_done");
    step(2);
    check("rstmid_fresh_issued", addr_log.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("rstmid_out%0d", i), out_at(i), 140 + i);
    check("rstmid_fresh_no_error", err0_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
